// File: rtl/moonbase_sram_bridge_if.sv
// ---------------------------------------------------------------------------
// moonbase_sram_bridge_if
// Bundles the CPU nibble-serial bus and the host byte-loader handshake that
// connect to moonbase_sram_bridge.
//   cpu_out    : CPU io_out byte (strobe, address, write enable, data strobe, nibble)
//   cpu_nibble : read nibble returned to the CPU
//   choose     : nibble phase, 0 = high nibble, 1 = low nibble
//   data_write : negative data strobe forwarded to the CPU side
//   ld_valid / ld_ready / ld_addr / ld_data : host loader handshake
//   wp_err     : sticky write-protect violation flag
// Modports: master (CPU + loader side), slave (the bridge).
// ---------------------------------------------------------------------------
interface moonbase_sram_bridge_if #(
   parameter int ADDR_W = 7
);
   logic [7:0]        cpu_out;
   logic [3:0]        cpu_nibble;
   logic              choose;
   logic              data_write;
   logic              ld_valid;
   logic              ld_ready;
   logic [ADDR_W-1:0] ld_addr;
   logic [7:0]        ld_data;
   logic              wp_err;

   // The CPU and the host loader sit on the master side
   modport master (
      output cpu_out, ld_valid, ld_addr, ld_data,
      input  cpu_nibble, choose, data_write, ld_ready, wp_err
   );

   // The bridge itself sits on the slave side
   modport slave (
      input  cpu_out, ld_valid, ld_addr, ld_data,
      output cpu_nibble, choose, data_write, ld_ready, wp_err
   );
endinterface

// File: rtl/moonbase_sram_bridge.sv
// ---------------------------------------------------------------------------
// moonbase_sram_bridge
// External byte store for moonbase_cpu_8bit. Decodes the CPU's nibble-serial
// bus, returns read nibbles combinationally, assembles written nibbles into
// bytes, and offers a host loader port for writing program images.
// Ports:
//   clk : single clock, all state changes on its rising edge
//   rst : asynchronous active-high reset (store contents are kept)
//   bus : moonbase_sram_bridge_if.slave (CPU bus + loader handshake + wp_err)
// Parameters:
//   ADDR_W   : address width, store holds 2**ADDR_W bytes
//   WP_LIMIT : first CPU-writable address when write protection is built in
// Build option:
//   SRAM_WPROT_EN : when defined, CPU commits below WP_LIMIT are dropped and
//                   flagged on the sticky wp_err output.
// ---------------------------------------------------------------------------
module moonbase_sram_bridge #(
   parameter int         ADDR_W   = 7,
   parameter logic [7:0] WP_LIMIT = 8'h40
) (
   input logic                    clk,
   input logic                    rst,
   moonbase_sram_bridge_if.slave  bus
);
   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {
      PhaseHigh = 1'b0,
      PhaseLow  = 1'b1
   } phase_t;

   phase_t            phase_q, phase_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        tmp_q, tmp_d;

   logic [7:0]        mem [DEPTH];

   logic              strobe;
   logic              cpuWrite;
   logic              cpuCommit;
   logic              commitAllowed;
   logic              loadAccept;
   logic [ADDR_W-1:0] readAddr;
   logic [7:0]        readByte;

   // Bus decode. CPU writes are masked while in reset so that a nibble
   // pattern on cpu_out can never commit a partial byte during reset, and so
   // the loader always sees ld_ready=1 while the CPU is held in reset.
   assign strobe    = bus.cpu_out[7];
   assign cpuWrite  = ~rst & ~strobe & ~bus.cpu_out[5];
   assign cpuCommit = cpuWrite & (phase_q == PhaseHigh);

   // The CPU commit always has priority over the loader for the single write port
   assign bus.ld_ready = ~cpuCommit;
   assign loadAccept   = bus.ld_valid & ~cpuCommit;

   // Read path is transparent: during an address strobe the new address is
   // looked up immediately instead of waiting for the registered copy
   assign readAddr       = strobe ? bus.cpu_out[ADDR_W-1:0] : addr_q;
   assign readByte       = mem[readAddr];
   assign bus.cpu_nibble = (phase_q == PhaseLow) ? readByte[3:0] : readByte[7:4];
   assign bus.choose     = (phase_q == PhaseLow);
   assign bus.data_write = strobe ? 1'b1 : bus.cpu_out[4];

`ifdef SRAM_WPROT_EN
   logic wpErr_q, wpErr_d;

   // Commits into the protected low region are dropped
   assign commitAllowed = 32'(addr_q) >= 32'(WP_LIMIT);
   assign bus.wp_err    = wpErr_q;

   // The violation flag is sticky and only cleared by reset
   always_comb begin
      wpErr_d = wpErr_q;
      if (cpuCommit && !commitAllowed) begin
         wpErr_d = 1'b1;
      end
   end

   // Register for the sticky violation flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wpErr_q <= 1'b0;
      end else begin
         wpErr_q <= wpErr_d;
      end
   end
`else
   assign commitAllowed = 1'b1;
   assign bus.wp_err    = 1'b0;
`endif

   // Next-state logic: a strobe loads the address and restarts at the high
   // nibble phase, every other cycle flips the phase. The low nibble of a
   // write is parked in tmp until the high nibble arrives to commit it.
   always_comb begin
      addr_d  = addr_q;
      phase_d = phase_q;
      tmp_d   = tmp_q;
      if (strobe) begin
         addr_d  = bus.cpu_out[ADDR_W-1:0];
         phase_d = PhaseHigh;
      end else begin
         phase_d = (phase_q == PhaseHigh) ? PhaseLow : PhaseHigh;
      end
      if (cpuWrite && (phase_q == PhaseLow)) begin
         tmp_d = bus.cpu_out[3:0];
      end
   end

   // State register. Reset clears address, phase and any half-written byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q  <= '0;
         phase_q <= PhaseHigh;
         tmp_q   <= 4'h0;
      end else begin
         addr_q  <= addr_d;
         phase_q <= phase_d;
         tmp_q   <= tmp_d;
      end
   end

   // Byte store. Deliberately not reset so a loaded image survives a CPU
   // reset; the loader keeps working while rst is high.
   always_ff @(posedge clk) begin
      if (cpuCommit && commitAllowed) begin
         mem[addr_q] <= {bus.cpu_out[3:0], tmp_q};
      end else if (loadAccept) begin
         mem[bus.ld_addr] <= bus.ld_data;
      end
   end
endmodule
